// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : alu_pkg                                                    |
// | Purpose  : Shared opcode constants, scheduler FSM state encoding and  |
// |            an opcode legality helper for alu_sched and alu4.          |
// | Ports    : none (package)                                             |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   // Opcodes above SUB (110, 111) are reserved and flagged as errors.
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= OP_SUB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : alu4                                                       |
// | Purpose  : Purely combinational ALU (AND/OR/XOR/NOT/ADD/SUB).         |
// | Ports    : a, b   [WIDTH]  operands                                   |
// |            op     [3]      opcode (alu_pkg OP_*)                      |
// |            result [WIDTH]  ALU result (0 for illegal opcodes)         |
// |            cout            ADD carry-out / SUB borrow, else 0         |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module alu4
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   // One extra bit captures the carry on ADD and the borrow on SUB
   // (the MSB of the zero-extended difference is set exactly when a < b).
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      cout   = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_ADD:  begin
            result = sum[WIDTH-1:0];
            cout   = sum[WIDTH];
         end
         OP_SUB:  begin
            result = diff[WIDTH-1:0];
            cout   = diff[WIDTH];
         end
         default: begin
            result = '0;
            cout   = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : alu_sched                                                  |
// | Purpose  : Two-requester round-robin front end for a shared ALU.      |
// |            IDLE -> EXEC -> DONE, one operation every three cycles.    |
// | Ports    : clk, rst                 clock, sync active-high reset     |
// |            req0/op0/a0/b0, ack0      requester 0 request / capture ack |
// |            req1/op1/a1/b1, ack1      requester 1 request / capture ack |
// |            result, result_id, cout, zero, err   registered outcome    |
// |            result_valid              one-cycle qualifier for outcome  |
// |            busy                      FSM not in IDLE                  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module alu_sched
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [2:0]       op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [2:0]       op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             result_id,
   output logic             cout,
   output logic             zero,
   output logic             err,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic             grant;       // a request is accepted at this edge
   logic             grant_id;    // which requester wins if granted
   logic             last_grant;  // requester granted most recently
   logic             owner;       // requester owning the captured operation
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;

   // On a tie the requester that did not win last time goes next.
   assign grant_id = (req0 && req1) ? ~last_grant : req1;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               grant     = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   alu4 #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_result),
      .cout   (alu_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         result_id    <= 1'b0;
         cout         <= 1'b0;
         zero         <= 1'b1;
         err          <= 1'b0;
      end else begin
         ack0         <= grant && !grant_id;
         ack1         <= grant &&  grant_id;
         result_valid <= (state == ST_EXEC);
         if (grant) begin
            last_grant <= grant_id;
            owner      <= grant_id;
            op_q       <= grant_id ? op1 : op0;
            a_q        <= grant_id ? a1  : a0;
            b_q        <= grant_id ? b1  : b0;
         end
         // Outcome registers only move when a new result is published,
         // so they hold steady between result_valid pulses.
         if (state == ST_EXEC) begin
            result    <= alu_result;
            cout      <= alu_cout;
            zero      <= (alu_result == '0);
            err       <= ~op_is_legal(op_q);
            result_id <= owner;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_alu_sched                                               |
// | Purpose  : Scoreboard bench for alu_sched: directed scenarios plus    |
// |            randomized traffic against a behavioural model.            |
// | Ports    : none                                                       |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_alu_sched;

   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic [2:0]       op0 = '0, op1 = '0;
   logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic             ack0, ack1, result_valid, result_id, cout, zero, err, busy;
   logic [WIDTH-1:0] result;

   alu_sched #(.WIDTH(WIDTH)) dut (
      .clk (clk), .rst (rst),
      .req0 (req0), .op0 (op0), .a0 (a0), .b0 (b0), .ack0 (ack0),
      .req1 (req1), .op1 (op1), .a1 (a1), .b1 (b1), .ack1 (ack1),
      .result (result), .result_valid (result_valid), .result_id (result_id),
      .cout (cout), .zero (zero), .err (err), .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             id;
      logic             cout;
      logic             zero;
      logic             err;
      int               due;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic rst_q = 1'b1;

   // Model state: edges until the ALU can accept again, and who won last.
   int   free_in = 0;
   logic last    = 1'b1;
   int   granted = -1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input int a, input int b, input logic id);
      exp_t e;
      int   r;
      e.cout = 1'b0;
      e.err  = 1'b0;
      e.id   = id;
      e.due  = 0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = (MOD - 1) - a;
         3'd4: begin r = a + b; e.cout = (r >= MOD); r = r % MOD; end
         3'd5: begin e.cout = (a < b); r = (a - b + MOD) % MOD; end
         default: begin r = 0; e.err = 1'b1; end
      endcase
      e.res  = r[WIDTH-1:0];
      e.zero = (r == 0);
      return e;
   endfunction

   // Advance one clock, apply the arbitration/timing rules to the inputs
   // that were present at that edge, and check the handshake outputs.
   task automatic tick();
      exp_t e;
      logic g1;
      logic e0, e1;
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      granted = -1;
      if (rst) begin
         free_in = 0;
         last    = 1'b1;
      end else if (free_in > 0) begin
         free_in--;
      end else if (req0 || req1) begin
         g1      = (req0 && req1) ? !last : req1;
         last    = g1;
         free_in = 2;
         granted = g1 ? 1 : 0;
         e       = g1 ? model(op1, int'(a1), int'(b1), 1'b1)
                      : model(op0, int'(a0), int'(b0), 1'b0);
         e.due   = cyc + 1;
         sbq.push_back(e);
         if (g1) e1 = 1'b1; else e0 = 1'b1;
      end
      chk("ack0", 32'(ack0), 32'(e0));
      chk("ack1", 32'(ack1), 32'(e1));
      chk("busy", 32'(busy), 32'(free_in != 0));
      if (e0) req0 = 1'b0;
      if (e1) req1 = 1'b0;
   endtask

   // Assert reset for one edge; any operation not yet published is lost.
   task automatic pulse_rst();
      rst = 1'b1;
      while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
      tick();
      rst = 1'b0;
   endtask

   task automatic issue(input int k, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
      bit done = 0;
      if (k == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (granted == k) done = 1;
      end
      if (!done) chk("grant_timeout", 32'(0), 32'(1));
      for (int i = 0; i < 5 && free_in != 0; i++) tick();
   endtask

   // Monitor: pops the scoreboard whenever the DUT publishes a result and
   // otherwise checks that the published outcome is held steady.
   logic [WIDTH-1:0] h_res  = '0;
   logic             h_id   = 1'b0, h_cout = 1'b0, h_zero = 1'b1, h_err = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_q) begin
         chk("valid_in_rst", 32'(result_valid), 32'(0));
         h_res = '0; h_id = 1'b0; h_cout = 1'b0; h_zero = 1'b1; h_err = 1'b0;
      end else if (result_valid) begin
         if (sbq.size() == 0) begin
            chk("spurious_valid", 32'(result_valid), 32'(0));
         end else begin
            e = sbq.pop_front();
            chk("valid_cycle", 32'(cyc), 32'(e.due));
            chk("result", 32'(result), 32'(e.res));
            chk("result_id", 32'(result_id), 32'(e.id));
            chk("cout", 32'(cout), 32'(e.cout));
            chk("zero", 32'(zero), 32'(e.zero));
            chk("err", 32'(err), 32'(e.err));
         end
         h_res = result; h_id = result_id; h_cout = cout; h_zero = zero; h_err = err;
      end else begin
         chk("hold", 32'({result, result_id, cout, zero, err}),
             32'({h_res, h_id, h_cout, h_zero, h_err}));
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("missing_valid", 32'(result_valid), 32'(1));
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[$];
      int exp_seq[4] = '{0, 1, 0, 1};

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      chk("rst_result", 32'(result), 32'(0));
      chk("rst_zero", 32'(zero), 32'(1));
      chk("rst_cout_err_id", 32'({cout, err, result_id}), 32'(0));
      chk("rst_valid", 32'(result_valid), 32'(0));

      // Requester 0 alone, a=0110 b=0011, every legal opcode.
      for (int op = 0; op < 6; op++) issue(0, 3'(op), 4'b0110, 4'b0011);

      // Arithmetic boundaries and illegal opcode followed by a legal one.
      issue(0, 3'b100, 4'b1111, 4'b0001);
      issue(1, 3'b101, 4'b0010, 4'b0101);
      issue(0, 3'b110, 4'b1010, 4'b0101);
      issue(0, 3'b111, 4'b0000, 4'b0000);
      issue(1, 3'b000, 4'b1111, 4'b1111);

      // Both requesters held and re-requested: strict alternation.
      for (int i = 0; i < 3; i++) pulse_rst();
      req0 = 1'b1; op0 = 3'b100; a0 = 4'd3; b0 = 4'd4;
      req1 = 1'b1; op1 = 3'b101; a1 = 4'd9; b1 = 4'd2;
      for (int i = 0; i < 14 && seq.size() < 4; i++) begin
         tick();
         if (granted >= 0) seq.push_back(granted);
         if (granted != 0 && !req0) req0 = 1'b1;
         if (granted != 1 && !req1) req1 = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("alt_count", 32'(seq.size()), 32'(4));
      for (int i = 0; i < 4 && i < seq.size(); i++) chk("alt_grant", 32'(seq[i]), 32'(exp_seq[i]));
      for (int i = 0; i < 4; i++) tick();

      // Reset during EXEC of a requester-0 op; the next tie goes to req0.
      req0 = 1'b1; op0 = 3'b010; a0 = 4'd5; b0 = 4'd6;
      for (int i = 0; i < 6 && granted != 0; i++) tick();
      pulse_rst();
      tick();
      req0 = 1'b1; req1 = 1'b1;
      tick();
      chk("tie_after_rst", 32'(granted), 32'(0));
      for (int i = 0; i < 8 && (req1 || free_in != 0); i++) tick();

      // req1 raised while a requester-0 op executes: waits until IDLE.
      req0 = 1'b1; op0 = 3'b001; a0 = 4'd1; b0 = 4'd8;
      tick();
      req1 = 1'b1; op1 = 3'b011; a1 = 4'd7; b1 = 4'd0;
      tick();
      tick();
      tick();
      chk("late_req1", 32'(granted), 32'(1));
      for (int i = 0; i < 3; i++) tick();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 59) == 0) begin
            rst = 1'b1;
            while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
         end
         if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; op0 = 3'($urandom_range(0, 7));
            a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
         end
         if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; op1 = 3'($urandom_range(0, 7));
            a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
         end
      end
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port req0  input  1  requester 0 wants one ALU operation.
REQ-005 Port op0  input  3  requester 0 opcode.
REQ-006 Port a0, b0  input  WIDTH  requester 0 operands.
REQ-007 Port ack0  output  1  one-cycle pulse: requester 0 operands captured.
REQ-008 Ports req1, op1, a1, b1, ack1: same as requester 0, for requester 1.
REQ-009 Port result  output  WIDTH  registered ALU result.
REQ-010 Port result_valid  output  1  one-cycle pulse qualifying result, result_id, cout, zero, err.
REQ-011 Port result_id  output  1  requester that owns result.
REQ-012 Port cout  output  1  add carry-out, or subtract borrow (a<b); 0 for logic ops.
REQ-013 Port zero  output  1  result == 0.
REQ-014 Port err  output  1  opcode was illegal.
REQ-015 Port busy  output  1  FSM not in IDLE.

Function
REQ-016 Opcodes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOT a (b ignored), 100 ADD, 101 SUB (a-b); 110 and 111 illegal.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-018 Illegal opcode SHALL give result=0, cout=0, zero=1, err=1, delivered with a normal result_valid pulse.
REQ-019 FSM states SHALL be IDLE, EXEC, DONE: IDLE->EXEC on a grant; EXEC->DONE always; DONE->IDLE always.
REQ-020 In IDLE with any req high at edge N, the winner's op/a/b SHALL be registered and its ack pulse high for cycle N+1 only.
REQ-021 Arbitration SHALL be round-robin: a lone requester wins; on a tie the requester not granted last wins; the last-grant pointer resets to 1, so req0 wins the first tie.
REQ-022 During EXEC the ALU SHALL evaluate the captured operands, and result/flags SHALL be registered so that result_valid is high for cycle N+2 only.
REQ-023 req inputs SHALL be ignored in EXEC and DONE; a requester SHALL drop req the cycle after its ack, and a held req SHALL be re-arbitrated as a new request.
REQ-024 Throughput SHALL be one operation per 3 cycles, with no overlapping operations.
REQ-025 result, result_id, cout, zero and err SHALL hold their values between result_valid pulses.
REQ-026 ack0 and ack1 SHALL never be high together.

Reset
REQ-027 rst SHALL put the FSM in IDLE; clear ack0, ack1, result_valid, result, cout, err, result_id and busy to 0; set zero=1; and set the pointer to 1.
REQ-028 rst asserted in EXEC or DONE SHALL discard the operation with no result_valid pulse; rst overrides a same-cycle grant.

Structure
REQ-029 Opcode constants and FSM state encodings SHALL live in a shared package alu_pkg.
REQ-030 The combinational ALU SHALL be a separate sub-module alu4 (a, b, op -> result, cout); alu_sched holds the FSM, arbiter and registers.

Verification
REQ-031 Requester 0 only, a=0110 b=0011, ops 000..101 in turn -> results 0010, 0111, 0101, 1001, 1001, 0011; ack at N+1 and result_valid at N+2 for each.
REQ-032 req0 and req1 together from reset, held and re-requested -> grants 0,1,0,1 alternating; result_id matches each grant.
REQ-033 ADD 1111+0001 -> result 0000, cout=1, zero=1; SUB 0010-0101 -> result 1101, cout=1, zero=0.
REQ-034 op=110 -> result 0000, err=1, zero=1; the next legal op gives err=0.
REQ-035 rst pulsed during EXEC -> no result_valid, busy=0 the next cycle, and the next tie goes to req0.
REQ-036 req1 raised during EXEC of a requester-0 op -> ignored until IDLE, then ack1 the cycle after IDLE.
